grf_wport_arbiter: RTL and testbench

- Shares the single GRF write port between two requesters:
  - the W-stage writeback of the 5-stage pipeline (primary), and
  - a long-latency execution unit such as MDU/coprocessor results (secondary, valid/ready).
- Queues secondary writes in a small FIFO and grants one write per cycle.
- Stalls the W stage when a queued write has starved for too long.
- Exposes a pending-destination lookup so the hazard unit can stall readers of registers still in flight.

---
 rtl/grf_wport_arbiter.sv | 157 +++++++++++++++
 tb/tb_grf_wport_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/grf_wport_arbiter.sv
// Single GRF write-port arbiter: W-stage writeback (primary) vs. queued secondary results.
// Optional commit trace enabled by defining GRF_WLOG_EN.
module grf_wport_arbiter #(
  parameter int DEPTH    = 2,
  parameter int WAIT_MAX = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        wb_we,
  input  logic [4:0]  wb_a3,
  input  logic [31:0] wb_wd,
  input  logic [31:0] wb_pc,
  output logic        wb_stall,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [4:0]  ex_a3,
  input  logic [31:0] ex_wd,
  input  logic [31:0] ex_pc,
  input  logic [4:0]  q_a,
  output logic        q_hit,
  output logic        grf_we,
  output logic [4:0]  grf_a3,
  output logic [31:0] grf_wd,
  output logic [31:0] grf_pc,
  output logic [31:0] commit_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

  logic [4:0]       a3_q [DEPTH];
  logic [31:0]      wd_q [DEPTH];
  logic [31:0]      pc_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [31:0]      commit_q, commit_d;

  logic wreq_s, empty_s, grant_w_s, grant_h_s, stall_s, push_s, hit_s;

  assign wreq_s  = wb_we && (wb_a3 != 5'd0);
  assign empty_s = (count_q == {CW{1'b0}});

  // Arbitration: W wins unless the queued head has been bypassed WAIT_MAX times.
  always_comb begin
    grant_w_s = 1'b0;
    grant_h_s = 1'b0;
    stall_s   = 1'b0;
    if (clr) begin
      grant_w_s = 1'b0;
    end else if (empty_s) begin
      grant_w_s = wreq_s;
    end else if (!wreq_s) begin
      grant_h_s = 1'b1;
    end else if (wait_q < WW'(WAIT_MAX)) begin
      grant_w_s = 1'b1;
    end else begin
      grant_h_s = 1'b1;
      stall_s   = 1'b1;
    end
  end

  // Write-port mux and hazard lookup over every valid slot.
  always_comb begin
    grf_we = grant_w_s || grant_h_s;
    grf_a3 = 5'd0;
    grf_wd = 32'd0;
    grf_pc = 32'd0;
    if (grant_w_s) begin
      grf_a3 = wb_a3;
      grf_wd = wb_wd;
      grf_pc = wb_pc;
    end else if (grant_h_s) begin
      grf_a3 = a3_q[rd_ptr_q];
      grf_wd = wd_q[rd_ptr_q];
      grf_pc = pc_q[rd_ptr_q];
    end else begin
      grf_a3 = 5'd0;
    end
    hit_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_s = hit_s | (valid_q[i] && (a3_q[i] == q_a));
    end
  end

  assign ex_ready   = !clr && (count_q < CW'(DEPTH));
  assign push_s     = ex_valid && ex_ready && (ex_a3 != 5'd0);
  assign q_hit      = !clr && hit_s && (q_a != 5'd0);
  assign wb_stall   = stall_s;
  assign commit_cnt = commit_q;

  // Next-state for FIFO bookkeeping, starvation counter and commit counter.
  always_comb begin
    valid_d  = valid_q;
    rd_ptr_d = rd_ptr_q + PW'(grant_h_s);
    wr_ptr_d = wr_ptr_q + PW'(push_s);
    count_d  = count_q + CW'(push_s) - CW'(grant_h_s);
    commit_d = commit_q + 32'(grf_we);
    if (grant_h_s) begin
      valid_d[rd_ptr_q] = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    if (push_s) begin
      valid_d[wr_ptr_q] = 1'b1;
    end else begin
      valid_d = valid_d;
    end
    if (empty_s || grant_h_s) begin
      wait_d = {WW{1'b0}};
    end else if (grant_w_s) begin
      wait_d = wait_q + WW'(1);
    end else begin
      wait_d = wait_q;
    end
  end

  // Control state; clr discards every pending entry.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      valid_q  <= {DEPTH{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      wait_q   <= {WW{1'b0}};
      commit_q <= 32'd0;
    end else begin
      valid_q  <= valid_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      wait_q   <= wait_d;
      commit_q <= commit_d;
    end
  end

  // Payload storage needs no reset: slots are qualified by valid_q.
  always_ff @(posedge clk) begin
    if (push_s) begin
      a3_q[wr_ptr_q] <= ex_a3;
      wd_q[wr_ptr_q] <= ex_wd;
      pc_q[wr_ptr_q] <= ex_pc;
    end
  end

`ifdef GRF_WLOG_EN
  // Commit trace in the grader format.
  always_ff @(posedge clk) begin
    if (grf_we) begin
      $display("%d@%h: $%d <= %h", commit_q + 32'd1, {20'h00003, grf_pc[11:0]}, grf_a3, grf_wd);
    end
  end
`endif

endmodule

// File: tb/tb_grf_wport_arbiter.sv
// Directed plus randomized bench for grf_wport_arbiter against a queue-based reference model.
module tb_grf_wport_arbiter;

  localparam int DEPTH    = 2;
  localparam int WAIT_MAX = 4;

  logic        clk = 1'b0;
  logic        clr;
  logic        wb_we, ex_valid;
  logic [4:0]  wb_a3, ex_a3, q_a;
  logic [31:0] wb_wd, wb_pc, ex_wd, ex_pc;
  logic        wb_stall, ex_ready, q_hit, grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd, grf_pc, commit_cnt;

  int errors = 0;
  int checks = 0;

  grf_wport_arbiter #(.DEPTH(DEPTH), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .clr(clr),
    .wb_we(wb_we), .wb_a3(wb_a3), .wb_wd(wb_wd), .wb_pc(wb_pc), .wb_stall(wb_stall),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_a3(ex_a3), .ex_wd(ex_wd), .ex_pc(ex_pc),
    .q_a(q_a), .q_hit(q_hit),
    .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc),
    .commit_cnt(commit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  int          m_wait = 0;
  logic [31:0] m_cnt  = 32'd0;
  logic        e_gw, e_gh, e_stall, e_push, e_ready, e_hit;
  logic [4:0]  e_a3;
  logic [31:0] e_wd, e_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs are already driven; let them settle, predict, and compare every output.
  task automatic settle_and_check();
    logic wreq;
    #1;
    e_gw = 1'b0; e_gh = 1'b0; e_stall = 1'b0; e_push = 1'b0; e_hit = 1'b0;
    e_a3 = 5'd0; e_wd = 32'd0; e_pc = 32'd0; e_ready = 1'b0;
    if (clr) begin
      mq.delete();
      m_wait = 0;
      m_cnt  = 32'd0;
    end else begin
      wreq    = wb_we && (wb_a3 != 5'd0);
      e_ready = (mq.size() < DEPTH);
      if (mq.size() == 0)         e_gw = wreq;
      else if (!wreq)             e_gh = 1'b1;
      else if (m_wait < WAIT_MAX) e_gw = 1'b1;
      else begin e_gh = 1'b1; e_stall = 1'b1; end
      if (e_gw) begin e_a3 = wb_a3; e_wd = wb_wd; e_pc = wb_pc; end
      if (e_gh) begin e_a3 = mq[0].a3; e_wd = mq[0].wd; e_pc = mq[0].pc; end
      foreach (mq[k]) if (q_a != 5'd0 && mq[k].a3 == q_a) e_hit = 1'b1;
      e_push = ex_valid && e_ready && (ex_a3 != 5'd0);
    end
    chk("grf_we",     32'(grf_we),   32'(e_gw || e_gh));
    chk("grf_a3",     32'(grf_a3),   32'(e_a3));
    chk("grf_wd",     grf_wd,        e_wd);
    chk("grf_pc",     grf_pc,        e_pc);
    chk("wb_stall",   32'(wb_stall), 32'(e_stall));
    chk("ex_ready",   32'(ex_ready), 32'(e_ready));
    chk("q_hit",      32'(q_hit),    32'(e_hit));
    chk("commit_cnt", commit_cnt,    m_cnt);
  endtask

  // Apply the predicted effects of the clock edge to the model.
  task automatic advance();
    ent_t e;
    @(posedge clk);
    if (!clr) begin
      if (e_gh) begin
        void'(mq.pop_front());
        m_wait = 0;
      end else if (e_gw && mq.size() > 0) begin
        m_wait++;
      end
      if (e_gw || e_gh) m_cnt = m_cnt + 32'd1;
      if (e_push) begin
        e.a3 = ex_a3; e.wd = ex_wd; e.pc = ex_pc;
        mq.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    clr = 1'b1;
    wb_we = 1'b0; wb_a3 = 5'd0; wb_wd = 32'd0; wb_pc = 32'd0;
    ex_valid = 1'b0; ex_a3 = 5'd0; ex_wd = 32'd0; ex_pc = 32'd0; q_a = 5'd0;
    @(posedge clk);
    @(negedge clk);

    // Reset holds everything quiet even with a W request present.
    wb_we = 1'b1; wb_a3 = 5'd5;
    settle_and_check();
    chk("rst_grf_we", 32'(grf_we), 32'd0);
    advance();
    clr = 1'b0;

    // W-only write, then a dropped write to $0.
    wb_we = 1'b1; wb_a3 = 5'd5; wb_wd = 32'h1234; wb_pc = 32'h3004;
    settle_and_check();
    chk("w_only_we", 32'(grf_we), 32'd1);
    chk("w_only_a3", 32'(grf_a3), 32'd5);
    advance();
    wb_a3 = 5'd0;
    settle_and_check();
    chk("w_zero_we",  32'(grf_we), 32'd0);
    chk("w_zero_cnt", commit_cnt,  32'd1);
    advance();

    // Secondary-only: visible and granted one cycle after the push.
    wb_we = 1'b0;
    ex_valid = 1'b1; ex_a3 = 5'd8; ex_wd = 32'hAAAA; ex_pc = 32'h3010; q_a = 5'd8;
    settle_and_check();
    chk("sec_hit_early", 32'(q_hit), 32'd0);
    advance();
    ex_valid = 1'b0;
    settle_and_check();
    chk("sec_hit",  32'(q_hit),  32'd1);
    chk("sec_a3",   32'(grf_a3), 32'd8);
    chk("sec_wd",   grf_wd,      32'hAAAA);
    advance();
    settle_and_check();
    chk("sec_hit_gone", 32'(q_hit), 32'd0);
    advance();

    // Back-to-back pushes while W keeps the port: full after two.
    wb_we = 1'b1; wb_a3 = 5'd4; wb_wd = 32'h44;
    for (int c = 0; c < 3; c++) begin
      ex_valid = 1'b1; ex_a3 = 5'(10 + c); ex_wd = 32'(c); ex_pc = 32'h3100 + 32'(4 * c);
      settle_and_check();
      chk("b2b_ready", 32'(ex_ready), (c == 2) ? 32'd0 : 32'd1);
      advance();
    end

    // Full with simultaneous pop: refused now, accepted next cycle.
    wb_we = 1'b0;
    settle_and_check();
    chk("fullpop_ready", 32'(ex_ready), 32'd0);
    chk("fullpop_a3",    32'(grf_a3),   32'd10);
    advance();
    settle_and_check();
    chk("after_pop_ready", 32'(ex_ready), 32'd1);
    chk("after_pop_a3",    32'(grf_a3),   32'd11);
    advance();
    ex_valid = 1'b0;
    settle_and_check();
    chk("late_push_a3", 32'(grf_a3), 32'd12);
    advance();
    settle_and_check();
    chk("cnt_no_gaps", commit_cnt, 32'd8);
    advance();

    // Starvation: four W grants, then forced head with stall, then the held W.
    ex_valid = 1'b1; ex_a3 = 5'd9; ex_wd = 32'h99; ex_pc = 32'h3200;
    settle_and_check();
    advance();
    ex_valid = 1'b0;
    wb_we = 1'b1; wb_a3 = 5'd3; wb_wd = 32'h33; wb_pc = 32'h3204;
    for (int c = 0; c < 6; c++) begin
      settle_and_check();
      chk("starve_stall", 32'(wb_stall), (c == 4) ? 32'd1 : 32'd0);
      chk("starve_a3",    32'(grf_a3),   (c == 4) ? 32'd9 : 32'd3);
      advance();
    end
    wb_we = 1'b0;
    settle_and_check();
    chk("starve_cnt", commit_cnt, 32'd14);
    advance();

    // Mid-cycle reset with two entries queued.
    wb_we = 1'b1; wb_a3 = 5'd1;
    for (int c = 0; c < 2; c++) begin
      ex_valid = 1'b1; ex_a3 = 5'(20 + c); ex_wd = 32'(c + 100); ex_pc = 32'h3300;
      settle_and_check();
      advance();
    end
    wb_we = 1'b0; ex_valid = 1'b0; q_a = 5'd20;
    #1;
    chk("pre_rst_we",  32'(grf_we), 32'd1);
    chk("pre_rst_hit", 32'(q_hit),  32'd1);
    clr = 1'b1;
    settle_and_check();
    chk("mid_rst_we",    32'(grf_we),   32'd0);
    chk("mid_rst_ready", 32'(ex_ready), 32'd0);
    advance();
    clr = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle_and_check();
      chk("post_rst_we", 32'(grf_we), 32'd0);
      advance();
    end

    // Randomized traffic; a stalled W request is re-presented unchanged.
    for (int n = 0; n < 600; n++) begin
      if (!e_stall) begin
        wb_we = 1'($urandom_range(0, 1));
        wb_a3 = 5'($urandom_range(0, 7));
        wb_wd = $urandom;
        wb_pc = 32'h3000 + 32'(4 * $urandom_range(0, 1023));
      end
      ex_valid = ($urandom_range(0, 2) == 0);
      ex_a3    = 5'($urandom_range(0, 7));
      ex_wd    = $urandom;
      ex_pc    = 32'h3000 + 32'(4 * $urandom_range(0, 1023));
      q_a      = 5'($urandom_range(0, 7));
      clr      = ($urandom_range(0, 99) == 0);
      settle_and_check();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
